// File: rtl/alu_issue_unit.sv
// alu_issue_unit: single-issue front end for a 4-bit registered ALU.
// Reads a 4x4 register file, drives ALU operands, retires result and flags.
module alu_issue_unit #(
  parameter int DATA_W = 4,
  parameter int NREGS  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [11:0]       instr,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  input  logic              alu_zero,
  output logic              carry_flag,
  output logic              zero_flag,
  output logic              done,
  output logic              busy,
  input  logic [1:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  state_e            state_q;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] alu_a_q;
  logic [DATA_W-1:0] alu_b_q;
  logic [2:0]        opcode_q;
  logic [IDX_W-1:0]  rd_q;
  logic              carry_q;
  logic              zero_q;
  logic              done_q;

  logic [2:0]        op_d;
  logic [IDX_W-1:0]  rd_d;
  logic [IDX_W-1:0]  rs1_d;
  logic [IDX_W-1:0]  rs2_d;
  logic              imm_en_d;
  logic [DATA_W-1:0] src2_d;
  logic [DATA_W-1:0] a_d;
  logic [DATA_W-1:0] b_d;
  logic              accept_s;
  logic              wb_en_s;

  // Field decode and operand fetch; only consumed on the accepting edge.
  always_comb begin
    op_d     = instr[11:9];
    rd_d     = instr[8:7];
    rs1_d    = instr[6:5];
    imm_en_d = instr[4];
    src2_d   = instr[3:0];
    rs2_d    = instr[1:0];
    a_d      = regs_q[rs1_d];
    if (imm_en_d) begin
      b_d = src2_d;
    end else begin
      b_d = regs_q[rs2_d];
    end
  end

  // Handshake and writeback strobes derive from state alone, so ready never loops back through valid.
  always_comb begin
    if (state_q == IDLE) begin
      accept_s = instr_valid;
    end else begin
      accept_s = 1'b0;
    end
    if (state_q == WB) begin
      wb_en_s = 1'b1;
    end else begin
      wb_en_s = 1'b0;
    end
  end

  // Issue FSM with registered operands, flags and retire pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      alu_a_q  <= {DATA_W{1'b0}};
      alu_b_q  <= {DATA_W{1'b0}};
      opcode_q <= 3'd0;
      rd_q     <= {IDX_W{1'b0}};
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            alu_a_q  <= a_d;
            alu_b_q  <= b_d;
            opcode_q <= op_d;
            rd_q     <= rd_d;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          state_q <= WB;
        end
        WB: begin
          // The ALU captured at the EXEC->WB edge, so its outputs are valid only now.
          carry_q <= alu_carry;
          zero_q  <= alu_zero;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Register file; writes land at the WB->IDLE edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (wb_en_s) begin
        regs_q[rd_q] <= alu_result;
      end
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_opcode  = opcode_q;
  assign carry_flag  = carry_q;
  assign zero_flag   = zero_q;
  assign done        = done_q;
  assign dbg_data    = regs_q[dbg_sel];

endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Issue and writeback stage sitting directly upstream of the 4-bit registered ALU. It accepts 12-bit instructions over a valid/ready handshake, reads operands from a 4-entry × 4-bit register file, drives the ALU operand and opcode inputs, and captures the ALU's registered result, carry and zero outputs. It then writes the result back to the destination register and to architectural flags. One instruction is in flight at a time.

## Interface
- DATA_W, 4, datapath width; must match the ALU (fixed at 4).
- NREGS, 4, register file depth; index width 2 (fixed).
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset; shared with the ALU.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  block can accept an instruction.
- instr  in  12  [11:9] opcode, [8:7] rd, [6:5] rs1, [4] imm_en, [3:0] src2. src2 is an immediate if imm_en=1; otherwise src2[1:0] selects rs2.
- alu_a  out  4  ALU operand a.
- alu_b  out  4  ALU operand b.
- alu_opcode  out  3  ALU opcode.
- alu_result  in  4  ALU registered result.
- alu_carry  in  1  ALU registered carry/borrow.
- alu_zero  in  1  ALU registered zero flag.
- carry_flag  out  1  architectural carry from the last retired instruction.
- zero_flag  out  1  architectural zero from the last retired instruction.
- done  out  1  one-cycle pulse, instruction retired.
- busy  out  1  high in any state other than IDLE.
- dbg_sel  in  2  debug register select.
- dbg_data  out  4  combinational read of regfile[dbg_sel]; reflects writes the cycle after they occur.

## Operation
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - instr_ready=1.
  - On instr_valid&&instr_ready at edge E0, latch instr fields and go to EXEC.
  - No transfer if instr_valid=0.
- EXEC:
  - alu_a = regfile[rs1].
  - alu_b = imm_en ? src2 : regfile[src2[1:0]].
  - alu_opcode = latched opcode.
  - Operands are registered at E0, so they are stable for the whole of EXEC and WB.
  - At the next edge (E1) the ALU captures its result; go to WB.
- WB:
  - Operands are held unchanged.
  - At edge E2: regfile[rd] <= alu_result, carry_flag <= alu_carry, zero_flag <= alu_zero, done <= 1, go to IDLE.
- done is high for exactly the one cycle following E2; otherwise 0.
- The block does not interpret opcodes. Carry for opcodes 010–111 is whatever the ALU reports (0 by design).
- Opcode 001 carry is a borrow: set when a < b.
- rd may equal rs1 or rs2. Operands are read at E0, before the write at E2, so old values are used.
- instr is sampled only at the accepting edge. Changes to instr while busy are ignored.
- Reset (any time, including mid-instruction):
  - FSM to IDLE; in-flight instruction discarded.
  - All regfile entries 0.
  - alu_a, alu_b, alu_opcode = 0.
  - carry_flag, zero_flag, done = 0.
  - busy = 0, instr_ready = 1 while rst_n low and after release.

## Timing
- Accept-to-retire: 2 cycles (E0→E2). done is visible in the cycle after E2.
- instr_ready returns high in the same cycle done is high; the next accept can occur at E2+1.
- Throughput: one instruction per 3 cycles under continuous instr_valid.
- instr_ready is a pure function of state. It does not depend on instr_valid, so there is no combinational loop.
- alu_* outputs change only at accept edges and at reset.
- The ALU result must be sampled in WB, not EXEC. In EXEC, alu_result still holds the previous instruction's value.

## Test plan
- **Reset state:** assert rst_n=0 mid-EXEC → next cycle busy=0, instr_ready=1, done=0, flags 0, all dbg_data reads = 0, alu_a/b/opcode = 0.
- **Immediate add with carry:**
  - Load r1=0xF via opcode 011 (OR), rs1=r0, imm 0xF.
  - Then ADD rd=r2, rs1=r1, imm 0x1.
  - Expect r2=0x0, carry_flag=1, zero_flag=1, done one cycle after E2.
- **Register subtract with borrow:**
  - r1=3, r2=5, SUB rd=r3, rs1=r1, rs2=r2.
  - Expect r3=0xE, carry_flag=1, zero_flag=0.
- **Self-overwrite:** r1=0x6, SHL rd=r1, rs1=r1 → r1=0xC, carry_flag=0. Confirms the old value was used as the operand.
- **Back-to-back handshake:**
  - Hold instr_valid=1 with 4 instructions.
  - Expect acceptances exactly every 3 cycles and instr_ready low during EXEC/WB.
  - Toggle instr while busy → no effect on the results.
- **Memory-lookup opcode:** r2=0x9, opcode 111, rs1=r2, rd=r0 → r0=0x9 (identity table after reset), zero_flag=0.
